bidir_bus_port: RTL
===================

Name: bidir_bus_port

Overview:
- Parametrised, clocked successor to the single-bit inout leaf driver.
- Owns a WIDTH-bit inout bus and arbitrates drive direction through a turnaround state machine.
- Presents valid/ready transmit and pulse-valid receive interfaces to the core.
- Sits between a core-side register block and a shared bidirectional net. It guarantees dead cycles on every direction change and flags bus contention.

Parameters:
WIDTH, 8, bus width in bits (>=1)
TURNAROUND, 2, high-Z dead cycles on each direction change (>=1)
SYNC_STAGES, 2, input sampling flops on io (>=1)
RESET_OUT, 0, value loaded into the output register at reset

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
io  inout  WIDTH  shared bus; driven only in TX state, else high-Z
dir_tx  input  1  1 = request to drive bus, 0 = request to receive
tx_data  input  WIDTH  data to drive
tx_valid  input  1  tx_data valid
tx_ready  output  1  transfer accepted when tx_valid && tx_ready
rx_data  output  WIDTH  last received, synchronised bus value
rx_valid  output  1  one-cycle pulse when rx_data updates
state  output  2  0=RX, 1=TURN_TX, 2=TX, 3=TURN_RX
contention  output  1  sticky: driven value not observed on bus

Behaviour:
- Reset (rst=1 at a clk edge) produces:
  - state=RX, out_q=RESET_OUT, rx_data=0, rx_valid=0, contention=0.
  - Sync chain cleared to 0; turnaround, holdoff and settle counters cleared.
  - Io is high-Z from that edge onward.
  - Reset mid-operation, including in TX, releases io at the next edge and discards any pending transfer.
- io = (state==TX) ? out_q : 'z. The drive enable is decoded from the registered state only, so io never glitches onto the bus during turnaround.
- FSM transitions:
  - RX: dir_tx=1 -> TURN_TX; load turn counter with TURNAROUND-1.
  - TURN_TX: dir_tx=0 -> RX immediately (abort). Counter==0 -> TX. Otherwise decrement.
  - TX: dir_tx=0 -> TURN_RX; load turn counter with TURNAROUND-1.
  - TURN_RX: counter==0 -> RX, otherwise decrement. dir_tx is ignored until RX is reached, so no abort in this state.
  - A request spends exactly TURNAROUND cycles in each TURN state; io is high-Z throughout.
- TX handshake:
  - tx_ready = (state==TX) && dir_tx, combinational.
  - On accept, out_q <= tx_data at that edge; io shows the new value from the next cycle.
  - out_q holds between transfers and across direction changes. On re-entry to TX, the last value is re-driven.
  - tx_valid while not ready: no effect. The source holds the data.
- Sampling:
  - io passes through SYNC_STAGES flops every cycle; sync_q is the last stage.
  - A holdoff counter loads SYNC_STAGES on entry to RX.
  - In RX with holdoff==0 and sync_q != rx_data: rx_data <= sync_q and rx_valid=1 for exactly one cycle.
  - rx_data holds in all other states; rx_valid is 0 outside RX.
- Contention:
  - A settle counter loads SYNC_STAGES+1 on entry to TX and on every out_q change.
  - In TX with settle==0 and sync_q != out_q: contention <= 1.
  - contention stays 1 until rst.
  - The comparison is bitwise !=; the bench keeps io resolved with weak pulls.

Test Plan (WIDTH=8, TURNAROUND=2, SYNC_STAGES=2):
1. Reset, then external driver puts 8'hA5 on io in RX.
   - rx_valid pulses once 3 cycles after the bus change (2 sync flops + register); rx_data=8'hA5.
   - io stays high-Z from the port.
2. dir_tx=1 at cycle N.
   - state=1 at N+1 and N+2, state=2 at N+3, io high-Z until N+3.
   - tx_valid with 8'h3C accepted at N+3; io=8'h3C from N+4; tx_ready=0 before N+3.
3. Back-to-back transfers 8'h01, 8'h02, 8'h03 with tx_valid held.
   - Three accepts in three cycles; io steps 01, 02, 03; contention stays 0.
4. In TX driving 8'hFF, external driver forces bit0 low.
   - contention=1 once the settle counter expires.
   - contention remains 1 after dir_tx=0 and the return to RX; it clears only on rst.
5. Direction edge cases:
   - dir_tx=1 for one cycle: aborts TURN_TX back to RX; io is never driven.
   - dir_tx toggles during TURN_RX: the FSM still completes 2 high-Z cycles and enters RX.
   - No rx_valid during the holdoff after entering RX.
6. rst asserted while in TX with tx_valid=1.
   - Next edge: state=0, io high-Z, out_q=RESET_OUT, tx_ready=0.
   - The pending transfer is not accepted.

Source files
------------

// File: rtl/bidir_bus_port.sv
// Clocked WIDTH-bit bidirectional bus port with a turnaround FSM.
// Provides a valid/ready transmit side, a pulsed receive side and a sticky contention flag.
module bidir_bus_port #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      TURNAROUND  = 2,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] io,
    input  logic             dir_tx,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic [1:0]       state,
    output logic             contention
);

    localparam int unsigned TURN_W   = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam int unsigned HOLD_W   = $clog2(SYNC_STAGES + 1);
    localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 2);

    localparam logic [TURN_W-1:0]   TURN_LOAD   = TURN_W'(TURNAROUND - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LOAD   = HOLD_W'(SYNC_STAGES);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ST_RX      = 2'd0,
        ST_TURN_TX = 2'd1,
        ST_TX      = 2'd2,
        ST_TURN_RX = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [TURN_W-1:0]   turn_q, turn_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic [WIDTH-1:0]    rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                contention_q, contention_d;
    logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]    sync_d [SYNC_STAGES];
    logic [WIDTH-1:0]    sampled;

    // Drive enable comes from registered state only, so turnaround cycles stay high-Z.
    assign io         = (state_q == ST_TX) ? out_q : {WIDTH{1'bz}};
    assign tx_ready   = (state_q == ST_TX) && dir_tx;
    assign sampled    = sync_q[SYNC_STAGES-1];
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign state      = state_q;
    assign contention = contention_q;

    always_comb begin
        state_d      = state_q;
        turn_d       = turn_q;
        hold_d       = hold_q;
        settle_d     = settle_q;
        out_d        = out_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        contention_d = contention_q;

        sync_d[0] = io;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end
        if (settle_q != '0) begin
            settle_d = settle_q - SETTLE_W'(1);
        end

        case (state_q)
            ST_RX: begin
                if (dir_tx) begin
                    state_d = ST_TURN_TX;
                    turn_d  = TURN_LOAD;
                end
            end
            ST_TURN_TX: begin
                if (!dir_tx) begin
                    state_d = ST_RX;
                    hold_d  = HOLD_LOAD;
                end else if (turn_q == '0) begin
                    state_d  = ST_TX;
                    settle_d = SETTLE_LOAD;
                end else begin
                    turn_d = turn_q - TURN_W'(1);
                end
            end
            ST_TX: begin
                if (!dir_tx) begin
                    state_d = ST_TURN_RX;
                    turn_d  = TURN_LOAD;
                end
            end
            ST_TURN_RX: begin
                if (turn_q == '0) begin
                    state_d = ST_RX;
                    hold_d  = HOLD_LOAD;
                end else begin
                    turn_d = turn_q - TURN_W'(1);
                end
            end
            default: state_d = ST_RX;
        endcase

        if (tx_ready && tx_valid) begin
            out_d = tx_data;
        end
        // A new driven value needs the sync chain to catch up before it can be judged.
        if (out_d != out_q) begin
            settle_d = SETTLE_LOAD;
        end

        if ((state_q == ST_RX) && (hold_q == '0) && (sampled != rx_data_q)) begin
            rx_data_d  = sampled;
            rx_valid_d = 1'b1;
        end
        if ((state_q == ST_TX) && (settle_q == '0) && (sampled != out_q)) begin
            contention_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RX;
            turn_q       <= '0;
            hold_q       <= '0;
            settle_q     <= '0;
            out_q        <= RESET_OUT;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            contention_q <= 1'b0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            turn_q       <= turn_d;
            hold_q       <= hold_d;
            settle_q     <= settle_d;
            out_q        <= out_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            contention_q <= contention_d;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

endmodule
